// File: rtl/mips_pkg.sv
// mips_pkg: shared Ctl bit indices, ALU control encodings, widths and EX/MEM control bundle.
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTL_W      = 6;
  localparam int CNT_W      = 32;
  localparam int CTL_REG_WRITE = 5;
  localparam int CTL_MEM_READ  = 4;
  localparam int CTL_MEM_WRITE = 3;
  localparam int CTL_MEM_TO_REG = 2;
  localparam int CTL_BRANCH    = 1;
  localparam int CTL_BRANCH_NE = 0;
  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctl_e;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctl_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch-taken decision and PC-relative target.
module branch_resolve #(
  parameter int DATA_W = 32
) (
  input  logic              branch_i,
  input  logic              branch_ne_i,
  input  logic              zero_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic              taken_o,
  output logic [DATA_W-1:0] target_o
);
  assign taken_o  = branch_i & (zero_i ^ branch_ne_i) & valid_i;
  assign target_o = pc_plus4_i + (imm_i << 2);
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution and forwarding view.
// Optional bubble counter output BubbleCount when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero,
  input  logic [DATA_W-1:0] RtData,
  input  logic [REG_AW-1:0] DestReg,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [DATA_W-1:0] Imm,
  input  logic [CTL_W-1:0]  Ctl,
  output logic              MemValid,
  output logic [DATA_W-1:0] MemALUResult,
  output logic [DATA_W-1:0] MemRtData,
  output logic [REG_AW-1:0] MemDestReg,
  output logic              MemRegWrite,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemToReg_o,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              FwdEn,
  output logic [REG_AW-1:0] FwdReg,
  output logic [DATA_W-1:0] FwdData
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  BubbleCount
`endif
);
  logic              bubble, load, taken;
  logic [DATA_W-1:0] target;
  mem_ctl_t          ctl_in;
  logic              valid_q, valid_d, taken_q, taken_d;
  mem_ctl_t          ctl_q, ctl_d;
  logic [DATA_W-1:0] alu_q, alu_d, rt_q, rt_d, target_q, target_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  branch_resolve #(.DATA_W(DATA_W)) u_branch_resolve (
    .branch_i    (Ctl[CTL_BRANCH]),
    .branch_ne_i (Ctl[CTL_BRANCH_NE]),
    .zero_i      (Zero),
    .valid_i     (InValid),
    .pc_plus4_i  (PCPlus4),
    .imm_i       (Imm),
    .taken_o     (taken),
    .target_o    (target)
  );
  // An invalid EX slot on a non-stalled edge is treated exactly like a flush.
  assign bubble = Flush | (~Stall & ~InValid);
  assign load   = ~Stall & ~bubble;
  assign ctl_in = '{reg_write: Ctl[CTL_REG_WRITE], mem_read: Ctl[CTL_MEM_READ],
                    mem_write: Ctl[CTL_MEM_WRITE], mem_to_reg: Ctl[CTL_MEM_TO_REG]};
  always_comb begin
    valid_d  = load ? 1'b1 : (bubble ? 1'b0 : valid_q);
    ctl_d    = load ? ctl_in : (bubble ? '0 : ctl_q);
    taken_d  = load ? taken : (bubble ? 1'b0 : taken_q);
    alu_d    = load ? ALUResult : alu_q;
    rt_d     = load ? RtData : rt_q;
    dest_d   = load ? DestReg : dest_q;
    target_d = load ? target : target_q;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      taken_q  <= 1'b0;
      alu_q    <= '0;
      rt_q     <= '0;
      dest_q   <= '0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
      taken_q  <= taken_d;
      alu_q    <= alu_d;
      rt_q     <= rt_d;
      dest_q   <= dest_d;
      target_q <= target_d;
    end
  end
  assign MemValid     = valid_q;
  assign MemALUResult = alu_q;
  assign MemRtData    = rt_q;
  assign MemDestReg   = dest_q;
  assign MemRegWrite  = ctl_q.reg_write;
  assign MemRead_o    = ctl_q.mem_read;
  assign MemWrite_o   = ctl_q.mem_write;
  assign MemToReg_o   = ctl_q.mem_to_reg;
  assign BranchTaken  = taken_q;
  assign BranchTarget = target_q;
  assign FwdEn        = valid_q & ctl_q.reg_write & (dest_q != '0);
  assign FwdReg       = dest_q;
  assign FwdData      = alu_q;
`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign BubbleCount = cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed plus random checks of ex_mem_stage against a behavioural model.
module tb_ex_mem_stage;
  logic        Clk = 1'b0, Rst = 1'b1, Stall = 1'b0, Flush = 1'b0, InValid = 1'b0, Zero = 1'b0;
  logic [31:0] ALUResult = '0, RtData = '0, PCPlus4 = '0, Imm = '0;
  logic [4:0]  DestReg = '0;
  logic [5:0]  Ctl = '0;
  logic        MemValid, MemRegWrite, MemRead_o, MemWrite_o, MemToReg_o, BranchTaken, FwdEn;
  logic [31:0] MemALUResult, MemRtData, BranchTarget, FwdData;
  logic [4:0]  MemDestReg, FwdReg;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] BubbleCount;
`endif
  int vectors = 0, miscompares = 0;
  bit m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken;
  longint m_alu, m_rt, m_dest, m_tgt, m_cnt;

  ex_mem_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .ALUResult(ALUResult), .Zero(Zero), .RtData(RtData), .DestReg(DestReg),
    .PCPlus4(PCPlus4), .Imm(Imm), .Ctl(Ctl),
    .MemValid(MemValid), .MemALUResult(MemALUResult), .MemRtData(MemRtData),
    .MemDestReg(MemDestReg), .MemRegWrite(MemRegWrite), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .MemToReg_o(MemToReg_o), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .FwdEn(FwdEn), .FwdReg(FwdReg), .FwdData(FwdData)
`ifdef EX_MEM_PERF_CNT_EN
    , .BubbleCount(BubbleCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken} = '0;
    m_alu = 0; m_rt = 0; m_dest = 0; m_tgt = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(MemValid), 64'(m_valid));
    chk({tag, ".alu"}, 64'(MemALUResult), 64'(m_alu));
    chk({tag, ".rt"}, 64'(MemRtData), 64'(m_rt));
    chk({tag, ".dest"}, 64'(MemDestReg), 64'(m_dest));
    chk({tag, ".ctl"}, 64'({MemRegWrite, MemRead_o, MemWrite_o, MemToReg_o}),
        64'({m_rw, m_mr, m_mw, m_m2r}));
    chk({tag, ".taken"}, 64'(BranchTaken), 64'(m_taken));
    chk({tag, ".target"}, 64'(BranchTarget), 64'(m_tgt));
    chk({tag, ".fwden"}, 64'(FwdEn), 64'(m_valid && m_rw && m_dest != 0));
    chk({tag, ".fwdreg"}, 64'(FwdReg), 64'(m_dest));
    chk({tag, ".fwddata"}, 64'(FwdData), 64'(m_alu));
`ifdef EX_MEM_PERF_CNT_EN
    chk({tag, ".bubbles"}, 64'(BubbleCount), 64'(m_cnt));
`endif
  endtask

  // Apply one edge: predict from the spec rules, clock, then compare 1 time unit later.
  task automatic tick(input string tag);
    if (Flush || (!Stall && !InValid)) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken} = '0;
      m_cnt = (m_cnt == 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
    end else if (!Stall) begin
      m_valid = 1;
      {m_rw, m_mr, m_mw, m_m2r} = Ctl[5:2];
      m_taken = Ctl[1] && (Zero != Ctl[0]);
      m_alu = ALUResult; m_rt = RtData; m_dest = DestReg;
      m_tgt = (longint'(PCPlus4) + 4 * longint'(Imm)) % 64'h1_0000_0000;
    end
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    ALUResult = $urandom; RtData = $urandom; PCPlus4 = $urandom; Imm = $urandom;
    DestReg = 5'($urandom); Ctl = 6'($urandom); Zero = 1'($urandom);
  endtask

  task automatic load(input logic [31:0] alu, input logic [4:0] dst, input logic [5:0] c,
                      input logic z, input logic [31:0] pc, input logic [31:0] im);
    ALUResult = alu; DestReg = dst; Ctl = c; Zero = z; PCPlus4 = pc; Imm = im;
    RtData = $urandom; InValid = 1; Stall = 0; Flush = 0;
  endtask

  initial begin
    model_reset();
    #2 check_all("reset");
    #10 Rst = 1'b0;
    @(negedge Clk);
    load(32'h10, 5'd8, 6'b100000, 1'b0, 32'h0, 32'h0);
    tick("fwd8");
    load(32'h55, 5'd3, 6'b010110, 1'b1, 32'h100, 32'hFFFF_FFFE);
    tick("beq_taken");
    load(32'h55, 5'd3, 6'b000011, 1'b1, 32'h100, 32'hFFFF_FFFE);
    tick("bne_not_taken");
    load(32'h77, 5'd0, 6'b101100, 1'b0, 32'hFFFF_FFFC, 32'h1);
    tick("dest0_wrap");
    load(32'hABCD, 5'd9, 6'b111110, 1'b0, 32'h40, 32'h3);
    tick("illegal_ctl");
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      InValid = 1'($urandom);
      tick("stall");
    end
    Flush = 1; rand_data();
    tick("stall_flush");
    Flush = 0; Stall = 0; InValid = 0; rand_data();
    tick("invalid");
    Flush = 1; InValid = 1;
    tick("flush");
    load(32'h1234, 5'd17, 6'b100000, 1'b0, 32'h8, 32'h8);
    tick("reload");
    Stall = 1; Flush = 1;
    #3 Rst = 1;
    model_reset();
    #1 check_all("async_rst");
    #2 Rst = 0;
    Stall = 0; Flush = 0; InValid = 1; rand_data();
    tick("post_rst_load");
    Flush = 1; tick("cnt_flush1");
    Flush = 0; InValid = 0; tick("cnt_invalid");
    Flush = 1; InValid = 1; tick("cnt_flush2");
`ifdef EX_MEM_PERF_CNT_EN
    chk("bubble_count3", 64'(BubbleCount), 64'd3);
`endif
    Flush = 0;
    #2 Rst = 1;
    model_reset();
    #1 check_all("cnt_rst");
    #1 Rst = 0;
    for (int i = 0; i < 200; i++) begin
      rand_data();
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      InValid = ($urandom_range(0, 3) != 0);
      tick("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width.
REQ-002 SHALL have parameter REG_AW, default 5: register-file address width.
REQ-003 SHALL have port Clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port Stall, input, 1: hold all stage registers.
REQ-006 SHALL have port Flush, input, 1: insert bubble.
REQ-007 SHALL have port InValid, input, 1: EX slot holds a real instruction.
REQ-008 SHALL have port ALUResult, input, DATA_W: ALU output.
REQ-009 SHALL have port Zero, input, 1: ALU zero flag.
REQ-010 SHALL have port RtData, input, DATA_W: store data.
REQ-011 SHALL have port DestReg, input, REG_AW: write-back destination.
REQ-012 SHALL have port PCPlus4, input, DATA_W: PC+4 of the EX instruction.
REQ-013 SHALL have port Imm, input, DATA_W: sign-extended immediate.
REQ-014 SHALL have port Ctl, input, 6: {RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe}.
REQ-015 SHALL have outputs MemValid (1), MemALUResult (DATA_W), MemRtData (DATA_W), MemDestReg (REG_AW), MemRegWrite, MemRead_o, MemWrite_o, MemToReg_o (1 each): registered stage contents.
REQ-016 SHALL have outputs BranchTaken (1) and BranchTarget (DATA_W): registered branch resolution to the PC mux.
REQ-017 SHALL have outputs FwdEn (1), FwdReg (REG_AW), FwdData (DATA_W): combinational forwarding view of the stage contents.

Function
REQ-018 Latency SHALL be one cycle: inputs sampled on a rising edge appear on outputs after that edge.
REQ-019 Priority per edge SHALL be Rst > Flush > Stall > normal load.
REQ-020 Flush SHALL clear MemValid, all control outputs, and BranchTaken; data registers SHALL hold their previous value.
REQ-021 Stall without Flush SHALL hold every register unchanged.
REQ-022 InValid=0 on load SHALL load a bubble identical to Flush.
REQ-023 Taken condition SHALL be Branch & (Zero XOR BranchNe) & InValid.
REQ-024 BranchTarget SHALL be PCPlus4 + (Imm << 2) truncated to DATA_W, wrap-around on overflow with no flag.
REQ-025 BranchTarget SHALL be loaded on every non-stalled, non-flushed edge; the value is meaningful only when BranchTaken=1.
REQ-026 FwdEn SHALL equal MemValid & MemRegWrite & (MemDestReg != 0); FwdReg = MemDestReg; FwdData = MemALUResult.
REQ-027 MemRead_o and MemWrite_o both set (illegal Ctl) SHALL be passed through unchanged; no arbitration.

Reset
REQ-028 Asserting Rst SHALL immediately, independent of Clk, drive all outputs to 0, including BranchTarget and the counter.
REQ-029 Rst asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion SHALL perform a normal load.

Configuration
REQ-030 With EX_MEM_PERF_CNT_EN defined, the block SHALL add output BubbleCount (32): a counter that increments on each edge loading a bubble (Flush, or InValid=0 and not Stall), saturates at 0xFFFFFFFF, and clears on Rst.
REQ-031 Without EX_MEM_PERF_CNT_EN, the port and counter SHALL NOT exist.

Structure
REQ-032 A shared package mips_pkg SHALL hold the Ctl bit indices, the ALUControl encodings (AND 0, OR 1, ADD 2, SUB 6, SLT 7), and the widths.
REQ-033 A combinational sub-module branch_resolve SHALL compute the taken condition and target; registers SHALL stay in ex_mem_stage.

Verification
REQ-034 ALUResult=0x00000010, DestReg=8, Ctl RegWrite=1, InValid=1 -> next edge: MemALUResult=0x10, FwdEn=1, FwdReg=8, FwdData=0x10.
REQ-035 Branch=1, BranchNe=0, Zero=1, PCPlus4=0x100, Imm=0xFFFFFFFE -> BranchTaken=1, BranchTarget=0xF8; same with BranchNe=1 -> BranchTaken=0.
REQ-036 Loaded state plus Stall=1 for 3 cycles while inputs change -> all outputs constant; Stall=1 together with Flush=1 -> MemValid=0, controls=0.
REQ-037 DestReg=0 with RegWrite=1 -> FwdEn=0; PCPlus4=0xFFFFFFFC, Imm=1 -> BranchTarget=0x00000000.
REQ-038 Rst pulse between clock edges mid-stream -> outputs 0 before the next edge; with EX_MEM_PERF_CNT_EN: 2 flushes plus 1 invalid load -> BubbleCount=3, then Rst -> 0.
